// File: rtl/clock_start_ctrl_if.sv
// Control and status bundle of the clock start/stop controller.
// The master side issues start/stop requests; the slave side returns enables and gated clocks.
interface clock_start_ctrl_if #(
    parameter int NCH   = 2,
    parameter int DIV_W = 8
);
    logic                   scan_en;
    logic [NCH-1:0]         start;
    logic [NCH-1:0]         stop;
    logic [NCH*DIV_W-1:0]   div;
    logic [NCH-1:0]         clk_en;
    logic [NCH-1:0]         gclk;
    logic [NCH-1:0]         running;
    logic [NCH-1:0]         busy;

    modport master (
        output scan_en, start, stop, div,
        input  clk_en, gclk, running, busy
    );

    modport slave (
        input  scan_en, start, stop, div,
        output clk_en, gclk, running, busy
    );
endinterface

// File: rtl/clock_start_ctrl.sv
// Multi-channel clock start/stop controller: per channel a start-delay / run / drain FSM
// producing a divided enable pulse, and a library-selected glitch-free clock gate.
module clock_start_ctrl #(
    parameter string LIB                     = "",
    parameter bit    NOT_IMPLEMENTED_IN_FPGA = 1'b0,
    parameter int    NCH                     = 2,
    parameter int    DIV_W                   = 8,
    parameter int    START_DLY               = 2
) (
    input logic                clk,
    input logic                rst_n,
    clock_start_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_WAIT      = 2'd1,
        ST_RUN       = 2'd2,
        ST_STOP_PEND = 2'd3
    } state_t;

    logic [NCH-1:0] clk_en_v;
    logic [NCH-1:0] gclk_v;
    logic [NCH-1:0] running_v;
    logic [NCH-1:0] busy_v;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        logic [3:0]       dcnt;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_q;
        logic             pulse;
        logic             gate_en;

        assign pulse = (cnt == div_q);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_OFF;
                dcnt  <= '0;
                cnt   <= '0;
                div_q <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        // stop wins over a simultaneous start
                        if (bus.start[i] && !bus.stop[i]) begin
                            state <= ST_WAIT;
                            div_q <= bus.div[i*DIV_W +: DIV_W];
                            dcnt  <= 4'(START_DLY);
                        end
                    end
                    ST_WAIT: begin
                        if (bus.stop[i]) begin
                            state <= ST_OFF;
                        end else if (dcnt == 4'd0) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                        end else begin
                            dcnt <= dcnt - 4'd1;
                        end
                    end
                    ST_RUN: begin
                        cnt <= pulse ? '0 : cnt + 1'b1;
                        // a stop on the pulse cycle makes that pulse the last one
                        if (bus.stop[i]) begin
                            state <= pulse ? ST_OFF : ST_STOP_PEND;
                        end
                    end
                    ST_STOP_PEND: begin
                        cnt <= pulse ? '0 : cnt + 1'b1;
                        if (pulse) begin
                            state <= ST_OFF;
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end

        // Outputs are pure decodes of flops, so the gate enable cannot glitch.
        assign clk_en_v[i]  = ((state == ST_RUN) || (state == ST_STOP_PEND)) && pulse;
        assign running_v[i] = (state == ST_RUN) || (state == ST_STOP_PEND);
        assign busy_v[i]    = (state != ST_OFF);
        assign gate_en      = clk_en_v[i] | bus.scan_en;

        if (LIB == "RTL") begin : g_gate_rtl
            logic en_lat;
            always_latch begin
                if (!clk) en_lat = gate_en;
            end
            assign gclk_v[i] = clk & en_lat;
        end else if (LIB == "NANGATE45") begin : g_gate_ng45
`ifdef SYNTHESIS
            CLKGATETST_X1 u_icg (
                .CK  (clk),
                .E   (clk_en_v[i]),
                .SE  (bus.scan_en),
                .GCK (gclk_v[i])
            );
`else
            // behavioural stand-in for the library ICG when cell models are not compiled in
            logic en_lat;
            always_latch begin
                if (!clk) en_lat = gate_en;
            end
            assign gclk_v[i] = clk & en_lat;
`endif
        end else if (LIB == "LIB_XILINX7") begin : g_gate_x7
            if (NOT_IMPLEMENTED_IN_FPGA) begin : g_bypass
                // consumers qualify with clk_en instead of a gated clock
                assign gclk_v[i] = clk;
            end else begin : g_bufgce
`ifdef SYNTHESIS
                BUFGCE u_bufgce (
                    .I  (clk),
                    .CE (gate_en),
                    .O  (gclk_v[i])
                );
`else
                logic en_lat;
                always_latch begin
                    if (!clk) en_lat = gate_en;
                end
                assign gclk_v[i] = clk & en_lat;
`endif
            end
        end else begin : g_gate_bad
`ifndef SYNTHESIS
`ifdef DEBUG_PRIMITIVE_LIB_PARAMETER
            initial begin
                $display("-E- incorrect parameter");
                $finish;
            end
`else
            $error("-E- incorrect parameter");
`endif
`endif
            assign gclk_v[i] = 1'b0;
        end
    end

    assign bus.clk_en  = clk_en_v;
    assign bus.gclk    = gclk_v;
    assign bus.running = running_v;
    assign bus.busy    = busy_v;

endmodule

// File: tb/tb_clock_start_ctrl.sv
// Scoreboard bench for clock_start_ctrl: the stimulus pushes per-cycle hand-computed
// expectations, an independent monitor pops and compares them against both DUT instances.
module tb_clock_start_ctrl;

    localparam int NCH   = 2;
    localparam int DIV_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    clock_start_ctrl_if #(.NCH(NCH), .DIV_W(DIV_W)) bif  ();
    clock_start_ctrl_if #(.NCH(NCH), .DIV_W(DIV_W)) bif5 ();

    clock_start_ctrl #(
        .LIB("RTL"), .NOT_IMPLEMENTED_IN_FPGA(1'b0),
        .NCH(NCH), .DIV_W(DIV_W), .START_DLY(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    clock_start_ctrl #(
        .LIB("RTL"), .NOT_IMPLEMENTED_IN_FPGA(1'b0),
        .NCH(NCH), .DIV_W(DIV_W), .START_DLY(5)
    ) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif5)
    );

    typedef struct {
        int         cyc;
        logic [1:0] en, run, bsy, gate;
        logic [1:0] en5, run5, bsy5, gate5;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         tcyc = 0;
    int         mcyc = 0;
    logic [1:0] prev_gate = 2'b00;
    logic [1:0] prev_gate5 = 2'b00;
    logic [1:0] gclk_hi = 2'b00;
    logic [1:0] gclk5_hi = 2'b00;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, mcyc, act, req);
        end
    endtask

    // gated clock level in the high phase of each cycle
    initial forever begin
        @(posedge clk);
        #1;
        gclk_hi  = bif.gclk;
        gclk5_hi = bif5.gclk;
    end

    // monitor: compares the DUT outputs of every cycle that has an expectation queued
    initial forever begin
        exp_t e;
        @(negedge clk);
        #2;
        while (sb.size() > 0 && sb[0].cyc < mcyc) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL stale_entry cycle %0d: got no compare expected cycle %0d", mcyc, e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == mcyc) begin
            e = sb.pop_front();
            check("clk_en",     bif.clk_en,   e.en);
            check("running",    bif.running,  e.run);
            check("busy",       bif.busy,     e.bsy);
            check("gclk",       gclk_hi,      e.gate);
            check("clk_en_d5",  bif5.clk_en,  e.en5);
            check("running_d5", bif5.running, e.run5);
            check("busy_d5",    bif5.busy,    e.bsy5);
            check("gclk_d5",    gclk5_hi,     e.gate5);
        end
        mcyc++;
    end

    // One clock cycle of stimulus plus the outputs expected during that cycle.
    task automatic tick(
        input logic       rn,
        input logic [1:0] st,
        input logic [1:0] sp,
        input logic       sc,
        input logic [1:0] e_en,
        input logic [1:0] e_run,
        input logic [1:0] e_bsy,
        input logic [1:0] st5   = 2'b00,
        input logic [1:0] sp5   = 2'b00,
        input logic [1:0] e_en5 = 2'b00,
        input logic [1:0] e_run5 = 2'b00,
        input logic [1:0] e_bsy5 = 2'b00
    );
        exp_t e;
        @(negedge clk);
        rst_n        = rn;
        bif.start    = st;
        bif.stop     = sp;
        bif.scan_en  = sc;
        bif5.start   = st5;
        bif5.stop    = sp5;
        bif5.scan_en = 1'b0;
        e.cyc   = tcyc;
        e.en    = e_en;
        e.run   = e_run;
        e.bsy   = e_bsy;
        e.gate  = prev_gate;
        e.en5   = e_en5;
        e.run5  = e_run5;
        e.bsy5  = e_bsy5;
        e.gate5 = prev_gate5;
        sb.push_back(e);
        // the latch opened in this low phase drives gclk in the next high phase
        prev_gate  = e_en | {2{sc}};
        prev_gate5 = e_en5;
        tcyc++;
    endtask

    task automatic reset_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        logic [1:0] en, run, bsy, st, sp, st5, sp5, en5, run5, bsy5;
        rst_n        = 1'b1;
        bif.start    = '0;
        bif.stop     = '0;
        bif.scan_en  = 1'b0;
        bif.div      = {8'd0, 8'd3};
        bif5.start   = '0;
        bif5.stop    = '0;
        bif5.scan_en = 1'b0;
        bif5.div     = {8'd3, 8'd3};
        #1 rst_n = 1'b0;

        // reset state
        reset_ticks(3);

        // start ch0, div=3: WAIT cycles 1..3, RUN from 4, pulses at 7, 11, 15
        for (int k = 0; k <= 16; k++) begin
            st  = {1'b0, k == 0};
            en  = {1'b0, (k == 7) || (k == 11) || (k == 15)};
            run = {1'b0, k >= 4};
            bsy = {1'b0, k >= 1};
            tick(1'b1, st, 2'b00, 1'b0, en, run, bsy);
        end
        reset_ticks(2);

        // div=0: enable continuously high once running
        bif.div = {8'd0, 8'd0};
        for (int k = 0; k <= 10; k++) begin
            st  = {1'b0, k == 0};
            en  = {1'b0, k >= 4};
            run = {1'b0, k >= 4};
            bsy = {1'b0, k >= 1};
            tick(1'b1, st, 2'b00, 1'b0, en, run, bsy);
        end
        reset_ticks(2);

        // div=2 both channels: ch0 stopped at cnt=0 drains one pulse, ch1 stopped on its pulse
        bif.div = {8'd2, 8'd2};
        for (int k = 0; k <= 13; k++) begin
            st  = (k == 0) ? 2'b11 : 2'b00;
            sp  = {k == 6, (k == 7) || (k == 8)};
            en  = {k == 6, (k == 6) || (k == 9)};
            run = {(k >= 4) && (k <= 6), (k >= 4) && (k <= 9)};
            bsy = {(k >= 1) && (k <= 6), (k >= 1) && (k <= 9)};
            tick(1'b1, st, sp, 1'b0, en, run, bsy);
        end
        reset_ticks(2);

        // aborts during WAIT, start+stop in OFF, and an undisturbed START_DLY=5 channel
        for (int k = 0; k <= 12; k++) begin
            st   = {k == 0, k <= 1};
            sp   = {k == 3, k <= 1};
            en   = 2'b00;
            run  = 2'b00;
            bsy  = {(k >= 1) && (k <= 3), 1'b0};
            st5  = (k == 0) ? 2'b11 : 2'b00;
            sp5  = {1'b0, k == 2};
            en5  = {k == 10, 1'b0};
            run5 = {k >= 7, 1'b0};
            bsy5 = {k >= 1, (k == 1) || (k == 2)};
            tick(1'b1, st, sp, 1'b0, en, run, bsy, st5, sp5, en5, run5, bsy5);
        end
        reset_ticks(2);

        // ch1 div=4 with a div change while running, then reset on a pulse cycle
        bif.div = {8'd4, 8'd0};
        for (int k = 0; k <= 17; k++) begin
            if (k == 5) bif.div = {8'd1, 8'd0};
            st  = {k == 0, 1'b0};
            en  = {k == 8, 1'b0};
            run = {(k >= 4) && (k < 13), 1'b0};
            bsy = {(k >= 1) && (k < 13), 1'b0};
            tick((k != 13) && (k != 14), st, 2'b00, 1'b0, en, run, bsy);
        end

        // restart picks up the new divide value
        for (int k = 0; k <= 10; k++) begin
            st  = {k == 0, 1'b0};
            en  = {(k == 5) || (k == 7) || (k == 9), 1'b0};
            run = {k >= 4, 1'b0};
            bsy = {k >= 1, 1'b0};
            tick(1'b1, st, 2'b00, 1'b0, en, run, bsy);
        end
        reset_ticks(2);

        // scan_en with every channel off
        for (int k = 0; k <= 7; k++) begin
            tick(1'b1, 2'b00, 2'b00, k <= 5, 2'b00, 2'b00, 2'b00);
        end

        @(negedge clk);
        @(negedge clk);
        #5;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clock_start_ctrl.md
Name: clock_start_ctrl

Overview:
- Multi-channel clock start/stop controller.
- Each channel is a programmable clock-enable divider with a start-delay and a drain-on-stop state machine.
- Each channel drives a glitch-free gated clock through a LIB-selected clock-gating primitive.
- Sits at the chip clock root, between the clock source buffer and the per-domain clock trees (core, peripherals).

Parameters:
- LIB, "", primitive library select: "RTL", "NANGATE45" or "LIB_XILINX7".
- NOT_IMPLEMENTED_IN_FPGA, 0, when 1 with LIB_XILINX7: gclk = clk ungated; consumers use clk_en.
- NCH, 2, number of independent channels (1..8).
- DIV_W, 8, divider value width per channel.
- START_DLY, 2, extra WAIT cycles before RUN (0..15).

Ports:
- clk  in  1  source clock.
- rst_n  in  1  async active-low reset (asynchronous assert, synchronous-to-clk deassert is the reset generator's job).
- scan_en  in  1  forces all gate enables high (test mode); does not affect the state machines.
- start  in  NCH  per-channel start request, level-sampled.
- stop  in  NCH  per-channel stop request, level-sampled.
- div  in  NCH*DIV_W  per-channel divide value; channel i uses div[i*DIV_W +: DIV_W]. Period = div+1 cycles.
- clk_en  out  NCH  one-cycle enable pulse per divided period.
- gclk  out  NCH  gated clock; gate enable = clk_en[i] | scan_en.
- running  out  NCH  channel in RUN or STOP_PEND.
- busy  out  NCH  channel not OFF.

Behaviour:
- Per-channel FSM states: OFF, WAIT, RUN, STOP_PEND. Registers per channel: state, dcnt (4b), cnt (DIV_W), div_q (DIV_W).
- Reset (rst_n=0, async): all channels OFF; cnt, dcnt, div_q = 0; clk_en = running = busy = 0. gclk low from the first clk low phase after reset assertion.
- Reset mid-operation aborts immediately; no drain.
- OFF:
  - start=1 & stop=0 → WAIT; div_q ← div; dcnt ← START_DLY.
  - start & stop both 1 → stay OFF (stop wins).
- WAIT:
  - Lasts exactly START_DLY+1 cycles: dcnt==0 → RUN with cnt ← 0; otherwise dcnt--.
  - stop=1 → OFF next cycle (abort); no clk_en pulse ever issued.
- RUN:
  - cnt increments each cycle; at cnt==div_q, cnt ← 0.
  - clk_en = (state ∈ {RUN, STOP_PEND}) & (cnt==div_q). clk_en is decoded from registers, so it is glitch-free at the gate input.
  - div_q = 0 → clk_en continuously high.
  - stop=1 in a non-pulse cycle → STOP_PEND.
  - stop=1 in a pulse cycle → that pulse is the last; OFF next cycle.
  - start is ignored.
- STOP_PEND:
  - Counting continues; the next clk_en pulse is issued, then OFF.
  - start and stop are ignored.
- Status decode: running = RUN|STOP_PEND; busy = state≠OFF.
- div changes after start acceptance are ignored until the next OFF→WAIT transition.
- Channels are fully independent; identical stimulus gives cycle-identical outputs.
- Gate primitive per channel, selected by LIB:
  - RTL: latch transparent while clk low, capturing the gate enable; gclk = clk & latch.
  - NANGATE45: CLKGATETST_X1 with CK=clk, E=clk_en[i], SE=scan_en, GCK=gclk[i].
  - LIB_XILINX7: BUFGCE with I=clk, CE=clk_en[i]|scan_en, O=gclk[i]; or a bypass when NOT_IMPLEMENTED_IN_FPGA=1.
- Unknown LIB: outside SYNTHESIS, elaboration must fail. Under DEBUG_PRIMITIVE_LIB_PARAMETER, print "-E- incorrect parameter" then $finish.
- The gate cell is the only LIB-dependent logic; the FSM is plain RTL.

Test Plan:
- Reset, then start[0] pulsed at edge 0, START_DLY=2, div=3:
  - busy=1 cycles 1+; running=1 from cycle 4.
  - clk_en[0] high in cycles 7, 11, 15; gclk[0] one clock pulse per clk_en (LIB="RTL").
- div=0 run: clk_en continuously high, gclk = clk.
- div=2 running, stop asserted mid-period (cnt=0):
  - exactly one more clk_en pulse (2 cycles later), then busy=0 the following cycle.
  - stop on the pulse cycle itself → no further pulse.
- Stop during WAIT, START_DLY=5: state OFF next cycle; zero clk_en pulses; start & stop together in OFF → remains OFF.
- rst_n dropped while channel 1 runs with div=4:
  - all outputs 0 immediately and gclk[1] quiet.
  - after release, channel idle until a new start; a div change while running has no effect until restart.
- scan_en=1 with all channels OFF:
  - every gclk toggles with clk; clk_en stays 0.
  - unknown LIB="FOO" with DEBUG_PRIMITIVE_LIB_PARAMETER → simulation ends with error message.
